// File: rtl/vinsn_dispatch_queue.sv
// rtl/vinsn_dispatch_queue.sv - vector instruction dispatch FIFO with in-flight cap and done-order check
//
// Buffers vector instructions from the scalar core and hands them in order to
// rvv_core. It limits the number of instructions issued but not yet done, and
// checks that completions come back in issue order.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   valid_i / ready_o                  push handshake from the scalar core
//   insn_i, insn_id_i, vec_context_i   pushed entry (encoding, ID, vl/vtype)
//   flush_i                            drop every queued, not-yet-issued entry
//   issue_valid_o / issue_ready_i      issue handshake toward rvv_core
//   issue_insn_o, issue_id_o,
//   issue_context_o                    head entry, meaningful while issue_valid_o
//   done_i, done_id_i                  completion report from rvv_core
//   inflight_o                         issued and not yet done
//   empty_o                            dispatch FIFO holds nothing
//   order_err_o                        sticky out-of-order / spurious done

module vinsn_dispatch_queue #(
    parameter int Depth       = 4,
    parameter int MaxInflight = 4,
    parameter int IdW         = 8,
    parameter int CtxW        = 16,
    localparam int CntW       = $clog2(MaxInflight + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     insn_i,
    input  logic [IdW-1:0]  insn_id_i,
    input  logic [CtxW-1:0] vec_context_i,
    input  logic            flush_i,
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    output logic [31:0]     issue_insn_o,
    output logic [IdW-1:0]  issue_id_o,
    output logic [CtxW-1:0] issue_context_o,
    input  logic            done_i,
    input  logic [IdW-1:0]  done_id_i,
    output logic [CntW-1:0] inflight_o,
    output logic            empty_o,
    output logic            order_err_o
);

    localparam int PtrW   = $clog2(Depth);
    localparam int IfPtrW = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;

    logic [31:0]     insn_mem [Depth];
    logic [IdW-1:0]  id_mem   [Depth];
    logic [CtxW-1:0] ctx_mem  [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW:0]   count;

    // IDs of issued instructions, oldest at if_rd
    logic [IdW-1:0]    if_mem [MaxInflight];
    logic [IfPtrW-1:0] if_wr;
    logic [IfPtrW-1:0] if_rd;
    logic [CntW-1:0]   inflight;
    logic              order_err;

    logic push;
    logic pop;
    logic done_pop;
    logic done_bad;

    // Explicit wrap so a single-entry in-flight FIFO still indexes in range
    function automatic logic [IfPtrW-1:0] if_next(input logic [IfPtrW-1:0] p);
        return (p == IfPtrW'(MaxInflight - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake outputs look only at state and flush_i, never at the other side's valid/ready
    assign empty_o       = (count == '0);
    assign ready_o       = (count < (PtrW + 1)'(Depth)) && !flush_i;
    assign issue_valid_o = !empty_o && (inflight < CntW'(MaxInflight)) && !flush_i;

    assign issue_insn_o    = insn_mem[rd_ptr];
    assign issue_id_o      = id_mem[rd_ptr];
    assign issue_context_o = ctx_mem[rd_ptr];
    assign inflight_o      = inflight;
    assign order_err_o     = order_err;

    assign push     = valid_i && ready_o;
    assign pop      = issue_valid_o && issue_ready_i;
    assign done_pop = done_i && (inflight != '0);
    // A done with nothing outstanding is also an ordering error
    assign done_bad = done_i && ((inflight == '0) || (done_id_i != if_mem[if_rd]));

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            insn_mem[wr_ptr] <= insn_i;
            id_mem[wr_ptr]   <= insn_id_i;
            ctx_mem[wr_ptr]  <= vec_context_i;
        end
        if (!rst_i && pop) begin
            if_mem[if_wr] <= id_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            if_wr     <= '0;
            if_rd     <= '0;
            inflight  <= '0;
            order_err <= 1'b0;
        end else begin
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;
            end

            // In-flight tracking survives flush: rvv_core still owns those instructions
            if (pop)      if_wr <= if_next(if_wr);
            if (done_pop) if_rd <= if_next(if_rd);
            if (pop && !done_pop)      inflight <= inflight + 1'b1;
            else if (!pop && done_pop) inflight <= inflight - 1'b1;

            if (done_bad) order_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vinsn_dispatch_queue.sv
// tb/tb_vinsn_dispatch_queue.sv - self-checking bench for vinsn_dispatch_queue

module tb_vinsn_dispatch_queue;

    localparam int Depth       = 4;
    localparam int MaxInflight = 4;
    localparam int IdW         = 8;
    localparam int CtxW        = 16;
    localparam int CntW        = $clog2(MaxInflight + 1);

    logic            clk = 1'b0;
    logic            rst_i = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [31:0]     insn_i = '0;
    logic [IdW-1:0]  insn_id_i = '0;
    logic [CtxW-1:0] vec_context_i = '0;
    logic            flush_i = 1'b0;
    logic            issue_valid_o;
    logic            issue_ready_i = 1'b0;
    logic [31:0]     issue_insn_o;
    logic [IdW-1:0]  issue_id_o;
    logic [CtxW-1:0] issue_context_o;
    logic            done_i = 1'b0;
    logic [IdW-1:0]  done_id_i = '0;
    logic [CntW-1:0] inflight_o;
    logic            empty_o;
    logic            order_err_o;

    always #5 clk = ~clk;

    vinsn_dispatch_queue #(
        .Depth(Depth), .MaxInflight(MaxInflight), .IdW(IdW), .CtxW(CtxW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .insn_i(insn_i), .insn_id_i(insn_id_i), .vec_context_i(vec_context_i),
        .flush_i(flush_i), .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_insn_o(issue_insn_o), .issue_id_o(issue_id_o),
        .issue_context_o(issue_context_o), .done_i(done_i), .done_id_i(done_id_i),
        .inflight_o(inflight_o), .empty_o(empty_o), .order_err_o(order_err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: plain queues of entries and of outstanding IDs
    typedef struct {
        logic [31:0]     insn;
        logic [IdW-1:0]  id;
        logic [CtxW-1:0] ctx;
    } entry_t;

    entry_t         m_q[$];
    logic [IdW-1:0] m_if[$];
    bit             m_err = 0;

    function automatic bit m_ready();
        return (m_q.size() < Depth) && !flush_i;
    endfunction

    function automatic bit m_issue_valid();
        return (m_q.size() > 0) && (m_if.size() < MaxInflight) && !flush_i;
    endfunction

    function automatic void model_compare();
        bit iv;
        iv = m_issue_valid();
        check("m_ready", 32'(ready_o), 32'(m_ready()));
        check("m_issue_valid", 32'(issue_valid_o), 32'(iv));
        check("m_inflight", 32'(inflight_o), 32'(m_if.size()));
        check("m_empty", 32'(empty_o), 32'(m_q.size() == 0));
        check("m_order_err", 32'(order_err_o), 32'(m_err));
        if (iv) begin
            check("m_issue_insn", issue_insn_o, m_q[0].insn);
            check("m_issue_id", 32'(issue_id_o), 32'(m_q[0].id));
            check("m_issue_ctx", 32'(issue_context_o), 32'(m_q[0].ctx));
        end
    endfunction

    function automatic void model_update();
        bit     rdy;
        bit     iv;
        entry_t e;
        rdy = m_ready();
        iv  = m_issue_valid();
        if (rst_i) begin
            m_q.delete();
            m_if.delete();
            m_err = 0;
        end else begin
            if (done_i) begin
                if (m_if.size() == 0) m_err = 1;
                else begin
                    if (m_if[0] != done_id_i) m_err = 1;
                    void'(m_if.pop_front());
                end
            end
            if (flush_i) m_q.delete();
            else begin
                if (iv && issue_ready_i) begin
                    e = m_q.pop_front();
                    m_if.push_back(e.id);
                end
                if (rdy && valid_i) begin
                    e.insn = insn_i; e.id = insn_id_i; e.ctx = vec_context_i;
                    m_q.push_back(e);
                end
            end
        end
    endfunction

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step_model();
        #3;
        model_compare();
        advance();
    endtask

    task automatic idle_inputs();
        rst_i = 0; valid_i = 0; flush_i = 0; issue_ready_i = 0; done_i = 0;
        insn_id_i = '0; done_id_i = '0; insn_i = '0; vec_context_i = '0;
    endtask

    typedef struct {
        bit             rst, valid;
        logic [IdW-1:0] id;
        bit             flush, ir, done;
        logic [IdW-1:0] did;
        bit             chk, rdy, iv;
        logic [IdW-1:0] iid;
        logic [CntW-1:0] infl;
        bit             emp, err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(bit rst, bit v, int id, bit f, bit ir, bit d, int did,
                       bit chk, bit rdy, bit iv, int iid, int infl, bit emp, bit err);
        vec_t t;
        t.rst = rst; t.valid = v; t.id = IdW'(id); t.flush = f; t.ir = ir; t.done = d;
        t.did = IdW'(did); t.chk = chk; t.rdy = rdy; t.iv = iv; t.iid = IdW'(iid);
        t.infl = CntW'(infl); t.emp = emp; t.err = err;
        tbl.push_back(t);
    endtask

    initial begin
        //   rst v  id f ir d did  chk rdy iv iid infl emp err
        add(1, 0,  0, 0, 0, 0, 0,  0,  0,  0, 0,  0,   0,  0);
        // in-order issue of 1,2,3, one cycle after each push
        add(0, 1,  1, 0, 1, 0, 0,  1,  1,  0, 0,  0,   1,  0);
        add(0, 1,  2, 0, 1, 0, 0,  1,  1,  1, 1,  0,   0,  0);
        add(0, 1,  3, 0, 1, 0, 0,  1,  1,  1, 2,  1,   0,  0);
        add(0, 0,  0, 0, 1, 0, 0,  1,  1,  1, 3,  2,   0,  0);
        add(0, 0,  0, 0, 0, 0, 0,  1,  1,  0, 0,  3,   1,  0);
        // matching done, then mismatched done (7 vs oldest 2)
        add(0, 0,  0, 0, 0, 1, 1,  1,  1,  0, 0,  3,   1,  0);
        add(0, 0,  0, 0, 0, 1, 7,  1,  1,  0, 0,  2,   1,  0);
        add(0, 0,  0, 0, 0, 0, 0,  1,  1,  0, 0,  1,   1,  1);
        add(0, 0,  0, 0, 0, 1, 3,  1,  1,  0, 0,  1,   1,  1);
        add(1, 0,  0, 0, 0, 0, 0,  1,  1,  0, 0,  0,   1,  1);
        // done with nothing in flight
        add(0, 0,  0, 0, 0, 1, 0,  1,  1,  0, 0,  0,   1,  0);
        add(0, 0,  0, 0, 0, 0, 0,  1,  1,  0, 0,  0,   1,  1);
        add(1, 0,  0, 0, 0, 0, 0,  1,  1,  0, 0,  0,   1,  1);
        // three queued (one issued) then flush
        add(0, 1, 10, 0, 0, 0, 0,  1,  1,  0, 0,  0,   1,  0);
        add(0, 1, 11, 0, 0, 0, 0,  1,  1,  1, 10, 0,   0,  0);
        add(0, 1, 12, 0, 1, 0, 0,  1,  1,  1, 10, 0,   0,  0);
        add(0, 1, 13, 1, 1, 0, 0,  1,  0,  0, 0,  1,   0,  0);
        add(0, 0,  0, 0, 0, 0, 0,  1,  1,  0, 0,  1,   1,  0);
        add(0, 0,  0, 0, 0, 1, 10, 1,  1,  0, 0,  1,   1,  0);
        add(0, 0,  0, 0, 0, 0, 0,  1,  1,  0, 0,  0,   1,  0);
        // fill to Depth with issue stalled, then drain into the in-flight cap
        add(0, 1, 20, 0, 0, 0, 0,  1,  1,  0, 0,  0,   1,  0);
        add(0, 1, 21, 0, 0, 0, 0,  1,  1,  1, 20, 0,   0,  0);
        add(0, 1, 22, 0, 0, 0, 0,  1,  1,  1, 20, 0,   0,  0);
        add(0, 1, 23, 0, 0, 0, 0,  1,  1,  1, 20, 0,   0,  0);
        add(0, 1, 24, 0, 0, 0, 0,  1,  0,  1, 20, 0,   0,  0);
        add(0, 1, 24, 0, 1, 0, 0,  1,  0,  1, 20, 0,   0,  0);
        add(0, 1, 24, 0, 1, 0, 0,  1,  1,  1, 21, 1,   0,  0);
        add(0, 0,  0, 0, 1, 0, 0,  1,  1,  1, 22, 2,   0,  0);
        add(0, 0,  0, 0, 1, 0, 0,  1,  1,  1, 23, 3,   0,  0);
        add(0, 0,  0, 0, 1, 0, 0,  1,  1,  0, 0,  4,   0,  0);
        add(0, 0,  0, 0, 1, 1, 20, 1,  1,  0, 0,  4,   0,  0);
        add(0, 0,  0, 0, 1, 0, 0,  1,  1,  1, 24, 3,   0,  0);
        add(0, 0,  0, 0, 0, 0, 0,  1,  1,  0, 0,  4,   1,  0);
        add(1, 0,  0, 0, 0, 0, 0,  1,  1,  0, 0,  4,   1,  0);

        idle_inputs();
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            rst_i = tbl[i].rst; valid_i = tbl[i].valid; insn_id_i = tbl[i].id;
            insn_i = 32'hAB00_0000 | 32'(tbl[i].id);
            vec_context_i = 16'hC000 | 16'(tbl[i].id);
            flush_i = tbl[i].flush; issue_ready_i = tbl[i].ir;
            done_i = tbl[i].done; done_id_i = tbl[i].did;
            #3;
            if (tbl[i].chk) begin
                check($sformatf("t%0d_ready", i), 32'(ready_o), 32'(tbl[i].rdy));
                check($sformatf("t%0d_issue_valid", i), 32'(issue_valid_o), 32'(tbl[i].iv));
                check($sformatf("t%0d_inflight", i), 32'(inflight_o), 32'(tbl[i].infl));
                check($sformatf("t%0d_empty", i), 32'(empty_o), 32'(tbl[i].emp));
                check($sformatf("t%0d_order_err", i), 32'(order_err_o), 32'(tbl[i].err));
                if (tbl[i].iv) begin
                    check($sformatf("t%0d_issue_id", i), 32'(issue_id_o), 32'(tbl[i].iid));
                    check($sformatf("t%0d_issue_insn", i), issue_insn_o,
                          32'hAB00_0000 | 32'(tbl[i].iid));
                    check($sformatf("t%0d_issue_ctx", i), 32'(issue_context_o),
                          32'(16'hC000 | 16'(tbl[i].iid)));
                end
            end
            advance();
        end

        // Same-cycle issue and done: inflight must hold steady
        idle_inputs();
        for (int k = 0; k < 13; k++) begin
            valid_i = 1; issue_ready_i = 1;
            insn_id_i = IdW'(40 + k); insn_i = $urandom; vec_context_i = 16'($urandom);
            done_i = (k >= 3);
            done_id_i = (m_if.size() > 0) ? m_if[0] : '0;
            #3;
            model_compare();
            if (k >= 3) check("steady_inflight", 32'(inflight_o), 32'd2);
            advance();
        end
        idle_inputs();
        #3;
        check("steady_no_err", 32'(order_err_o), 32'd0);
        advance();

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst_i         = ($urandom_range(0, 299) == 0);
            valid_i       = ($urandom_range(0, 3) != 0);
            insn_i        = $urandom;
            insn_id_i     = IdW'($urandom);
            vec_context_i = 16'($urandom);
            flush_i       = ($urandom_range(0, 49) == 0);
            issue_ready_i = ($urandom_range(0, 2) != 0);
            done_i        = 0;
            done_id_i     = IdW'($urandom);
            if (m_if.size() > 0 && $urandom_range(0, 2) == 0) begin
                done_i = 1;
                if ($urandom_range(0, 39) != 0) done_id_i = m_if[0];
            end else if (m_if.size() == 0 && $urandom_range(0, 199) == 0) begin
                done_i = 1;
            end
            step_model();
        end

        idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
